mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage, directly downstream of EX and upstream of write-back.
- Consumes the EX/MEM bundle: ALU result, store data, rd, and the MemRead/MemWrite/MemToReg/RegWrite controls.
- Performs loads and stores against a variable-latency data memory using a req/ack handshake, and stalls upstream while an access is outstanding.
- Registers the MEM/WB outputs that drive the register-file write-back.

Parameters:
- ADDR_WIDTH, 64, width of the memory address (taken from ex_alu_result).
- TIMEOUT_CYCLES, 16, number of WAIT cycles without ack before the access is aborted; must be ≥1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX/MEM bundle holds a valid instruction.
- ex_alu_result  in  64  ALU result; used as the memory address or as pass-through data.
- ex_store_data  in  64  store data (read_data2 path).
- ex_rd  in  5  destination register.
- ex_MemRead  in  1  load.
- ex_MemWrite  in  1  store.
- ex_MemToReg  in  1  selects memory data for write-back.
- ex_RegWrite  in  1  instruction writes the register file.
- stall  out  1  upstream must hold the EX/MEM bundle stable while high.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  64  write data.
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.
- mem_rdata  in  64  read data.
- wb_valid  out  1  write-back bundle valid (1-cycle pulse per retired instruction).
- wb_RegWrite  out  1  perform the register write.
- wb_rd  out  5  write register.
- wb_data  out  64  write data.
- bus_error  out  1  1-cycle pulse when an access times out.
- align_fault  out  1  1-cycle pulse on a misaligned access (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clock edge):
  - State returns to IDLE.
  - All registered outputs clear to 0: mem_req, mem_we, mem_addr, mem_wdata, wb_*, bus_error, align_fault. The timeout counter clears to 0.
  - A reset taken in WAIT abandons the access. mem_req is 0 on the next cycle, and a late mem_ack is ignored.
- is_mem = ex_MemRead | ex_MemWrite. If both are set, the instruction is treated as a read and mem_we=0.
- FSM states: IDLE and WAIT.
- IDLE, ex_valid and !is_mem:
  - On the next edge: wb_valid=1, wb_rd=ex_rd, wb_data=ex_alu_result, wb_RegWrite=ex_RegWrite & (ex_rd!=31).
  - Latency is 1 cycle; stall=0.
- IDLE, ex_valid and is_mem:
  - stall=1 combinationally.
  - On the next edge: mem_req=1, mem_we=ex_MemWrite & !ex_MemRead, mem_addr=ex_alu_result, mem_wdata=ex_store_data. The counter clears and the state moves to WAIT.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - stall = !mem_ack, and stall=0 in the abort cycle. Upstream therefore advances on the edge ending the ack or abort cycle.
- WAIT, mem_ack==1:
  - On the next edge: mem_req=0, state returns to IDLE, wb_valid=1, wb_rd=ex_rd.
  - Load: wb_data = ex_MemToReg ? mem_rdata : ex_alu_result, and wb_RegWrite = ex_RegWrite & (ex_rd!=31).
  - Store: wb_RegWrite=0.
  - Minimum load/store latency: issue cycle + 1 WAIT cycle, so wb_valid appears 2 cycles after the op is presented.
- WAIT, no ack:
  - The counter increments every cycle.
  - In the cycle where counter==TIMEOUT_CYCLES-1 and no ack arrives, the access aborts. On the next edge: mem_req=0, state returns to IDLE, bus_error=1 for 1 cycle, wb_valid=1, wb_RegWrite=0.
  - If ack and timeout occur in the same cycle, the ack wins.
- mem_ack while in IDLE is ignored.
- wb_valid, bus_error and align_fault are 1-cycle pulses; they are 0 in any cycle without a retirement or fault event.
- ex_valid==0 in IDLE: wb_valid=0 next cycle, and the other wb_* hold their values.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: in IDLE, an is_mem op with ex_alu_result[2:0]!=0 is not issued.
  - mem_req stays 0 and stall=0.
  - On the next edge: align_fault=1 for 1 cycle, wb_valid=1, wb_RegWrite=0.
- Undefined: align_fault is tied to 0 and the access is issued with the unmodified address.

Test Plan:
- ALU op: ex_valid=1, RegWrite=1, rd=5, alu_result=0x1234, no mem -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, wb_RegWrite=1, stall=0.
- Load with immediate ack: MemRead, MemToReg, rd=3, addr=0x40; mem_ack=1 with rdata=0xDEADBEEF in the first WAIT cycle -> mem_req high for exactly 1 cycle, stall high for 1 cycle, wb_data=0xDEADBEEF, wb_RegWrite=1.
- Store with 5-cycle ack delay: addr=0x80, store_data=0xAA -> mem_we=1 and mem_wdata=0xAA held stable for 5 cycles, stall high until the ack cycle, wb_valid=1 with wb_RegWrite=0.
- Timeout (TIMEOUT_CYCLES=16): load, no ack -> abort in the 16th WAIT cycle, bus_error pulse, wb_RegWrite=0; a second load immediately after proceeds normally.
- Edge cases:
  - rd=31 load -> wb_RegWrite=0.
  - Reset pulled low mid-WAIT -> mem_req=0 and all outputs 0 next cycle; a subsequent stray ack produces no wb_valid.
- With MEM_ACCESS_ALIGN_CHECK_EN: load at addr=0x44 -> no mem_req, align_fault=1 and wb_valid=1 one cycle later. Without the macro: mem_req=1 with mem_addr=0x44.

Source files
------------

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack handshake, stalls EX while waiting, registers MEM/WB.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [63:0]           ex_alu_result,
  input  logic [63:0]           ex_store_data,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_MemWrite,
  input  logic                  ex_MemToReg,
  input  logic                  ex_RegWrite,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [63:0]           mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic [4:0]            wb_rd,
  output logic [63:0]           wb_data,
  output logic                  bus_error,
  output logic                  align_fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_mem;
  logic             misalign;
  logic             timeout_hit;
  logic             rd_writable;

  assign is_mem      = ex_MemRead | ex_MemWrite;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // x31 is treated as a read-only register for write-back
  assign rd_writable = (ex_rd != 5'd31);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = (ex_alu_result[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE: stall = ex_valid & is_mem & ~misalign;
      S_WAIT: stall = ~mem_ack & ~timeout_hit;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      bus_error   <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      bus_error   <= 1'b0;
      align_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (is_mem && !misalign) begin
              mem_req   <= 1'b1;
              mem_we    <= ex_MemWrite & ~ex_MemRead;
              mem_addr  <= ex_alu_result[ADDR_WIDTH-1:0];
              mem_wdata <= ex_store_data;
              cnt       <= '0;
              state     <= S_WAIT;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_result;
              if (is_mem) begin
                wb_RegWrite <= 1'b0;
                align_fault <= 1'b1;
              end else begin
                wb_RegWrite <= ex_RegWrite & rd_writable;
              end
            end
          end
        end
        S_WAIT: begin
          // Ack takes priority over a simultaneous timeout
          if (mem_ack) begin
            mem_req     <= 1'b0;
            state       <= S_IDLE;
            wb_valid    <= 1'b1;
            wb_rd       <= ex_rd;
            wb_data     <= (!mem_we && ex_MemToReg) ? mem_rdata : ex_alu_result;
            wb_RegWrite <= ~mem_we & ex_RegWrite & rd_writable;
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            state       <= S_IDLE;
            bus_error   <= 1'b1;
            wb_valid    <= 1'b1;
            wb_rd       <= ex_rd;
            wb_data     <= ex_alu_result;
            wb_RegWrite <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of ALU ops plus hand-written load/store/timeout/reset/alignment sequences.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegWrite;
  logic        stall, mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        bus_error, align_fault;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.ADDR_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
    .ex_RegWrite(ex_RegWrite), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_error(bus_error), .align_fault(align_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        regwrite;
    logic        exp_regwrite;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_rd = 0;
    ex_MemRead = 0; ex_MemWrite = 0; ex_MemToReg = 0; ex_RegWrite = 0;
  endtask

  task automatic present_load(input logic [4:0] rd, input logic [63:0] addr);
    clear_ex();
    ex_valid = 1; ex_MemRead = 1; ex_MemToReg = 1; ex_RegWrite = 1;
    ex_rd = rd; ex_alu_result = addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    alu_vec_t vecs[4];
    vecs[0] = '{5'd5,  64'h1234,               1'b1, 1'b1};
    vecs[1] = '{5'd31, 64'hFFFF,               1'b1, 1'b0};
    vecs[2] = '{5'd7,  64'h0,                  1'b0, 1'b0};
    vecs[3] = '{5'd0,  64'h8000_0000_0000_0001, 1'b1, 1'b1};

    clear_ex();
    mem_ack = 0; mem_rdata = 0;
    reset = 0;
    step(); step();
    check("reset_mem_req", mem_req, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_data", wb_data, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_stall", stall, 0);
    reset = 1;
    step();

    // Pass-through ALU ops
    foreach (vecs[i]) begin
      clear_ex();
      ex_valid = 1; ex_rd = vecs[i].rd; ex_alu_result = vecs[i].alu; ex_RegWrite = vecs[i].regwrite;
      #1;
      check("alu_stall", stall, 0);
      step();
      check("alu_wb_valid", wb_valid, 1);
      check("alu_wb_rd", wb_rd, vecs[i].rd);
      check("alu_wb_data", wb_data, vecs[i].alu);
      check("alu_wb_regwrite", wb_RegWrite, vecs[i].exp_regwrite);
      check("alu_mem_req", mem_req, 0);
    end
    clear_ex();
    step();
    check("idle_wb_valid", wb_valid, 0);
    check("idle_wb_rd_hold", wb_rd, 0);
    check("idle_wb_data_hold", wb_data, 64'h8000_0000_0000_0001);

    // Load with immediate ack
    present_load(5'd3, 64'h40);
    #1;
    check("ld_issue_stall", stall, 1);
    step();
    check("ld_mem_req", mem_req, 1);
    check("ld_mem_we", mem_we, 0);
    check("ld_mem_addr", mem_addr, 64'h40);
    check("ld_wb_valid_early", wb_valid, 0);
    mem_ack = 1; mem_rdata = 64'hDEADBEEF;
    #1;
    check("ld_ack_stall", stall, 0);
    step();
    mem_ack = 0; clear_ex();
    check("ld_mem_req_drop", mem_req, 0);
    check("ld_wb_valid", wb_valid, 1);
    check("ld_wb_rd", wb_rd, 3);
    check("ld_wb_data", wb_data, 64'hDEADBEEF);
    check("ld_wb_regwrite", wb_RegWrite, 1);
    step();
    check("ld_wb_pulse", wb_valid, 0);

    // Store with 5-cycle ack delay
    clear_ex();
    ex_valid = 1; ex_MemWrite = 1; ex_rd = 5'd9; ex_alu_result = 64'h80; ex_store_data = 64'hAA;
    step();
    for (int i = 0; i < 4; i++) begin
      check("st_mem_req", mem_req, 1);
      check("st_mem_we", mem_we, 1);
      check("st_mem_wdata", mem_wdata, 64'hAA);
      check("st_mem_addr", mem_addr, 64'h80);
      check("st_stall", stall, 1);
      step();
    end
    mem_ack = 1;
    #1;
    check("st_ack_mem_we", mem_we, 1);
    check("st_ack_stall", stall, 0);
    step();
    mem_ack = 0; clear_ex();
    check("st_wb_valid", wb_valid, 1);
    check("st_wb_regwrite", wb_RegWrite, 0);
    check("st_mem_req_drop", mem_req, 0);

    // Timeout: 16 WAIT cycles without ack
    present_load(5'd6, 64'h100);
    step();
    for (int i = 0; i < 15; i++) begin
      check("to_wait_stall", stall, 1);
      check("to_wait_req", mem_req, 1);
      step();
    end
    check("to_abort_stall", stall, 0);
    check("to_no_err_yet", bus_error, 0);
    step();
    check("to_bus_error", bus_error, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_regwrite", wb_RegWrite, 0);
    check("to_mem_req", mem_req, 0);
    present_load(5'd4, 64'h48);
    step();
    check("to2_bus_error_pulse", bus_error, 0);
    check("to2_mem_req", mem_req, 1);
    check("to2_mem_addr", mem_addr, 64'h48);
    mem_ack = 1; mem_rdata = 64'h55;
    step();
    mem_ack = 0; clear_ex();
    check("to2_wb_valid", wb_valid, 1);
    check("to2_wb_data", wb_data, 64'h55);
    check("to2_wb_regwrite", wb_RegWrite, 1);

    // Load to x31 never writes
    present_load(5'd31, 64'h8);
    step();
    mem_ack = 1; mem_rdata = 64'h77;
    step();
    mem_ack = 0; clear_ex();
    check("r31_wb_valid", wb_valid, 1);
    check("r31_wb_regwrite", wb_RegWrite, 0);

    // Reset mid-WAIT, then a stray ack
    present_load(5'd2, 64'h200);
    step();
    step();
    check("rst_pre_req", mem_req, 1);
    reset = 0;
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_regwrite", wb_RegWrite, 0);
    reset = 1; clear_ex();
    mem_ack = 1; mem_rdata = 64'h99;
    #1;
    check("rst_stray_stall", stall, 0);
    step();
    check("rst_stray_wb_valid", wb_valid, 0);
    check("rst_stray_mem_req", mem_req, 0);
    mem_ack = 0;
    step();
    check("rst_stray_wb_valid2", wb_valid, 0);

    // Misaligned load
    present_load(5'd8, 64'h44);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    #1;
    check("al_stall", stall, 0);
    step();
    clear_ex();
    check("al_mem_req", mem_req, 0);
    check("al_fault", align_fault, 1);
    check("al_wb_valid", wb_valid, 1);
    check("al_wb_regwrite", wb_RegWrite, 0);
    step();
    check("al_fault_pulse", align_fault, 0);
`else
    #1;
    check("al_stall", stall, 1);
    step();
    check("al_mem_req", mem_req, 1);
    check("al_mem_addr", mem_addr, 64'h44);
    check("al_fault", align_fault, 0);
    mem_ack = 1; mem_rdata = 64'h1;
    step();
    mem_ack = 0; clear_ex();
    check("al_wb_valid", wb_valid, 1);
    check("al_fault_after", align_fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
